// File: rtl/adc_multi_controller.sv
// Multi-channel ADCxx1S101 capture controller: shared SCLK/CS_N, parallel shift-in,
// per-channel offset/saturate/bit-select/invert, then serial drain into the pixel FIFO.
module adc_multi_controller #(
  parameter int NUM_CH     = 1,
  parameter int ADC_BITS   = 12,
  parameter int LEAD_ZEROS = 3,
  parameter int OUT_BITS   = 8,
  parameter int BIT_OFFSET = 1,
  parameter int INVERT     = 1,
  parameter int CH_BITS    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_start,
  input  logic [7:0]          track_counts,
  input  logic [ADC_BITS-1:0] val_offset,
  input  logic [NUM_CH-1:0]   sdata,
  input  logic                fifo_full,
  output logic                capture_done,
  output logic                overrun,
  output logic                fifo_wr_en,
  output logic [OUT_BITS-1:0] fifo_wr_data,
  output logic [CH_BITS-1:0]  fifo_wr_ch,
  output logic                sclk,
  output logic                cs_n
);

  localparam int SEL_W  = OUT_BITS + BIT_OFFSET;
  localparam int PH_MAX = (2*ADC_BITS > 256) ? 2*ADC_BITS : 256;
  localparam int CNT_W  = $clog2(PH_MAX);

  typedef enum logic [2:0] {IDLE, TRACK, ZEROS, READ, DRAIN} state_t;

  state_t               state;
  logic                 pending;
  logic [CNT_W-1:0]     timer;
  logic [CH_BITS-1:0]   ch_idx;
  logic [ADC_BITS-1:0]  raw [NUM_CH];

  logic [7:0]           trk_m1;
  logic                 track_last;
  logic                 last_wr;
  logic                 consume;
  logic                 go;
  logic [ADC_BITS-1:0]  sel;
  logic [ADC_BITS:0]    diff;
  logic [ADC_BITS-1:0]  mag;
  logic [OUT_BITS-1:0]  code;

  // A zero track length behaves as a single-cycle track phase.
  assign trk_m1     = (track_counts == 8'd0) ? 8'd0 : track_counts - 8'd1;
  assign track_last = (timer >= CNT_W'(trk_m1));

  assign last_wr = (state == DRAIN) && !fifo_full && (ch_idx == CH_BITS'(NUM_CH-1));
  assign consume = (state == IDLE) || last_wr;
  assign go      = consume && (pending || capture_start);

  assign fifo_wr_en = (state == DRAIN) && !fifo_full;
  assign fifo_wr_ch = ch_idx;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_idx == CH_BITS'(i)) sel = raw[i];
  end

  // The extra top bit of diff is the borrow, i.e. the sign of raw - offset.
  assign diff = {1'b0, sel} - {1'b0, val_offset};
  assign mag  = diff[ADC_BITS-1:0];

  always_comb begin
    if (diff[ADC_BITS])
      code = '0;
    else if ((mag >> SEL_W) != '0)
      code = '1;
    else
      code = OUT_BITS'(mag >> BIT_OFFSET);
  end

  assign fifo_wr_data = (INVERT != 0) ? ~code : code;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      timer        <= '0;
      ch_idx       <= '0;
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      capture_done <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) raw[i] <= '0;
    end else begin
      capture_done <= 1'b0;
      overrun      <= capture_start && pending && !consume;
      pending      <= consume ? (pending && capture_start) : (pending || capture_start);

      // Sample on the clk edge that ends a high sclk phase.
      if (state == READ && sclk)
        for (int i = 0; i < NUM_CH; i++) raw[i] <= {raw[i][ADC_BITS-2:0], sdata[i]};

      case (state)
        IDLE: begin
          if (go) begin
            state <= TRACK;
            timer <= '0;
          end
        end
        TRACK: begin
          if (track_last) begin
            state        <= ZEROS;
            timer        <= '0;
            cs_n         <= 1'b0;
            sclk         <= 1'b0;
            capture_done <= 1'b1;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ZEROS: begin
          sclk <= ~sclk;
          if (timer == CNT_W'(2*LEAD_ZEROS-1)) begin
            state <= READ;
            timer <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        READ: begin
          if (timer == CNT_W'(2*ADC_BITS-1)) begin
            state  <= DRAIN;
            cs_n   <= 1'b1;
            sclk   <= 1'b1;
            ch_idx <= '0;
          end else begin
            sclk  <= ~sclk;
            timer <= timer + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (last_wr) begin
            ch_idx <= '0;
            timer  <= '0;
            state  <= go ? TRACK : IDLE;
          end else if (!fifo_full) begin
            ch_idx <= ch_idx + CH_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_multi_controller.sv
// Bench for adc_multi_controller: two 4-channel instances (inverting and non-inverting),
// an ADC pin model, and a cycle-relative transaction model of each capture.
module tb_adc_multi_controller;

  localparam int NCH = 4;
  localparam int AB  = 12;
  localparam int LZ  = 3;
  localparam int OB  = 8;
  localparam int CHB = 2;
  localparam int L   = 2*LZ + 2*AB;

  logic           clk = 1'b0;
  logic           reset;
  logic           capture_start;
  logic [7:0]     track_counts;
  logic [AB-1:0]  val_offset;
  logic [NCH-1:0] sdata;
  logic           fifo_full;

  logic           a_done, a_ovr, a_wr, a_sclk, a_csn;
  logic [OB-1:0]  a_data;
  logic [CHB-1:0] a_ch;
  logic           b_done, b_ovr, b_wr, b_sclk, b_csn;
  logic [OB-1:0]  b_data;
  logic [CHB-1:0] b_ch;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  adc_multi_controller #(.NUM_CH(NCH), .ADC_BITS(AB), .LEAD_ZEROS(LZ), .OUT_BITS(OB),
                         .BIT_OFFSET(1), .INVERT(1), .CH_BITS(CHB)) ua (
    .clk(clk), .reset(reset), .capture_start(capture_start), .track_counts(track_counts),
    .val_offset(val_offset), .sdata(sdata), .fifo_full(fifo_full),
    .capture_done(a_done), .overrun(a_ovr), .fifo_wr_en(a_wr), .fifo_wr_data(a_data),
    .fifo_wr_ch(a_ch), .sclk(a_sclk), .cs_n(a_csn));

  adc_multi_controller #(.NUM_CH(NCH), .ADC_BITS(AB), .LEAD_ZEROS(LZ), .OUT_BITS(OB),
                         .BIT_OFFSET(2), .INVERT(0), .CH_BITS(CHB)) ub (
    .clk(clk), .reset(reset), .capture_start(capture_start), .track_counts(track_counts),
    .val_offset(val_offset), .sdata(sdata), .fifo_full(fifo_full),
    .capture_done(b_done), .overrun(b_ovr), .fifo_wr_en(b_wr), .fifo_wr_data(b_data),
    .fifo_wr_ch(b_ch), .sclk(b_sclk), .cs_n(b_csn));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OB-1:0] conv(input int raw, input int off, input int bo, input bit inv);
    int d;
    logic [OB-1:0] c;
    d = raw - off;
    if (d < 0) c = '0;
    else if (d >= (1 << (OB + bo))) c = '1;
    else c = OB'(d >> bo);
    return inv ? ~c : c;
  endfunction

  // Capture model state, all in absolute cycle numbers.
  bit  busy = 0, pending = 0, ovr_next = 0, fin, go, newp, dr;
  bit  e_cs, e_sclk, e_done, e_wr;
  int  cyc = 0, s = 0, tcur = 1, wd = 0, rel = 0;
  int  start_cyc = 0, done_cyc = -1, first_wr_cyc = -1, ovr_seen = 0, tog = 0, last_tog = 0;
  int  raw_cur[NCH];
  int  raw_q[$];
  logic [OB-1:0] first_a, first_b;
  logic prev_csn = 1'b1, prev_msclk = 1'b1;

  task automatic start_capture();
    busy         = 1;
    s            = cyc + 1;
    start_cyc    = cyc;
    tcur         = (track_counts == 8'd0) ? 1 : int'(track_counts);
    wd           = 0;
    first_wr_cyc = -1;
    done_cyc     = -1;
    for (int i = 0; i < NCH; i++) begin
      if (raw_q.size() > 0) raw_cur[i] = raw_q.pop_front();
      else if ($urandom_range(0, 1) == 1) raw_cur[i] = int'($urandom_range(0, 4095));
      else raw_cur[i] = int'($urandom_range(0, 1023));
    end
  endtask

  task automatic check_pins(input string p, input logic csn, input logic sck, input logic done,
                            input logic ovr, input logic wr);
    chk({p, "_cs_n"}, csn, e_cs);
    chk({p, "_sclk"}, sck, e_sclk);
    chk({p, "_capture_done"}, done, e_done);
    chk({p, "_overrun"}, ovr, ovr_next);
    chk({p, "_fifo_wr_en"}, wr, e_wr);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_a_cs_n"}, a_csn, 1'b1);
    chk({p, "_a_sclk"}, a_sclk, 1'b1);
    chk({p, "_a_done"}, a_done, 1'b0);
    chk({p, "_a_ovr"}, a_ovr, 1'b0);
    chk({p, "_a_wr"}, a_wr, 1'b0);
    chk({p, "_a_data"}, a_data, 8'hFF);
    chk({p, "_a_ch"}, a_ch, 2'd0);
    chk({p, "_b_cs_n"}, b_csn, 1'b1);
    chk({p, "_b_wr"}, b_wr, 1'b0);
    chk({p, "_b_data"}, b_data, 8'h00);
  endtask

  // Checks the cycle just completed, then advances the model by one cycle.
  always @(negedge clk) begin
    if (reset) begin
      busy = 0; pending = 0; ovr_next = 0; tog = 0;
    end else begin
      e_cs = 1; e_sclk = 1; e_done = 0; e_wr = 0; dr = 0; rel = 0;
      if (busy) begin
        rel = cyc - s;
        if (rel >= tcur && rel < tcur + L) begin
          e_cs   = 0;
          e_sclk = ((rel - tcur) % 2) == 1;
          e_done = (rel == tcur);
        end else if (rel >= tcur + L) begin
          dr   = 1;
          e_wr = !fifo_full;
        end
      end
      check_pins("a", a_csn, a_sclk, a_done, a_ovr, a_wr);
      check_pins("b", b_csn, b_sclk, b_done, b_ovr, b_wr);
      if (e_wr) begin
        chk("a_ch", a_ch, wd);
        chk("b_ch", b_ch, wd);
        chk("a_data", a_data, conv(raw_cur[wd], int'(val_offset), 1, 1));
        chk("b_data", b_data, conv(raw_cur[wd], int'(val_offset), 2, 0));
        if (wd == 0 && first_wr_cyc < 0 && a_wr) begin
          first_wr_cyc = cyc; first_a = a_data; first_b = b_data;
        end
      end
      if (a_done) done_cyc = cyc;
      if (a_ovr) ovr_seen++;
      if (!a_csn && a_sclk !== prev_msclk) tog++;
      if (a_csn && !prev_csn) begin last_tog = tog; tog = 0; end

      ovr_next = 0;
      fin = dr && !fifo_full && (wd == NCH - 1);
      if (dr && !fifo_full) wd++;
      if (!busy || fin) begin
        go   = pending || capture_start;
        newp = pending && capture_start;
        busy = 0;
        if (go) start_capture();
        pending = newp;
      end else if (capture_start) begin
        if (pending) ovr_next = 1;
        else pending = 1;
      end
    end
    prev_csn = a_csn; prev_msclk = a_sclk;
    cyc++;
  end

  // ADC pin model: leading zeros then MSB-first data, each bit presented after an sclk fall.
  int  nfall = 0, adc_idx = 0;
  logic prev_sclk = 1'b1;
  always @(posedge clk) begin
    #1;
    if (a_csn) nfall = 0;
    else if (!a_sclk && prev_sclk) begin
      nfall++;
      adc_idx = nfall - 1 - LZ;
      for (int i = 0; i < NCH; i++)
        sdata[i] = (adc_idx >= 0 && adc_idx < AB) ? raw_cur[i][AB-1-adc_idx] : 1'($urandom_range(0, 1));
    end
    prev_sclk = a_sclk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    capture_start = 1'b1;
    step();
    capture_start = 1'b0;
  endtask

  task automatic wait_rel(input int target, input int maxc);
    bit hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      if (busy && (cyc - s) == target) hit = 1;
      else step();
    end
    chk("wait_phase", hit, 1'b1);
  endtask

  task automatic wait_idle(input int maxc);
    bit hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      if (!busy && !pending) hit = 1;
      else step();
    end
    chk("wait_idle", hit, 1'b1);
  endtask

  int ovr0;

  initial begin
    reset = 1'b1; capture_start = 1'b0; fifo_full = 1'b0;
    track_counts = 8'd14; val_offset = '0; sdata = '0;
    repeat (3) step();
    chk_reset("rst");
    reset = 1'b0;
    step();

    // Nominal single capture.
    val_offset = 12'h020;
    raw_q.push_back(12'h0A5);
    for (int i = 1; i < NCH; i++) raw_q.push_back(int'($urandom_range(0, 4095)));
    pulse_start();
    wait_idle(200);
    chk("done_latency", done_cyc - start_cyc, 15);
    chk("wr_latency", first_wr_cyc - start_cyc, 45);
    chk("wr_data_0A5", first_a, 8'hBD);
    chk("sclk_toggles", last_tog, 30);

    // Saturation, both directions.
    raw_q.push_back(12'h010); raw_q.push_back(12'h400); raw_q.push_back(12'h220); raw_q.push_back(12'h021);
    pulse_start();
    wait_idle(200);
    chk("sat_neg_inv", first_a, 8'hFF);
    chk("sat_neg_noinv", first_b, 8'h00);
    val_offset = 12'h000;
    raw_q.push_back(12'h400); raw_q.push_back(12'h1FF); raw_q.push_back(12'h200); raw_q.push_back(12'h000);
    pulse_start();
    wait_idle(200);
    chk("sat_pos_inv", first_a, 8'h00);
    chk("sat_pos_noinv", first_b, 8'hFF);

    // Request in READ, then a dropped one during a 10-cycle DRAIN stall.
    track_counts = 8'd5; val_offset = 12'h040;
    ovr0 = ovr_seen;
    pulse_start();
    wait_rel(5 + 2*LZ + 4, 100);
    pulse_start();
    wait_rel(5 + L, 100);
    fifo_full = 1'b1;
    repeat (3) step();
    pulse_start();
    repeat (6) step();
    fifo_full = 1'b0;
    wait_idle(300);
    chk("overrun_once", ovr_seen - ovr0, 1);

    // Reset in the middle of READ with a request pending.
    val_offset = 12'h000; track_counts = 8'd3;
    pulse_start();
    wait_rel(3 + 2*LZ + 2, 100);
    pulse_start();
    wait_rel(3 + 2*LZ + 6, 100);
    reset = 1'b1;
    step();
    chk_reset("midrst");
    reset = 1'b0;
    repeat (20) step();
    val_offset = 12'h011;
    pulse_start();
    wait_idle(300);

    // Randomised traffic with stalls and overlapping requests.
    for (int i = 0; i < 3000; i++) begin
      if (!busy && !pending) begin
        track_counts = 8'($urandom_range(0, 20));
        val_offset   = 12'($urandom_range(0, 12'h300));
      end
      capture_start = ($urandom_range(0, 15) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      step();
    end
    capture_start = 1'b0;
    fifo_full     = 1'b0;
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/adc_multi_controller.md
# adc_multi_controller

Parametrised successor to the single-channel stonyman pixel ADC controller. Drives up to four TI ADCxx1S101-family serial ADCs that share one SCLK/CS_N pair, with one SDATA line per channel. Each capture converts all channels in parallel, then applies offset subtraction, saturation, bit selection and optional inversion. The block then serialises the per-channel results into the pixel FIFO, tagging each write with its channel number. It sits between the stonyman sequencer (capture_start / capture_done) and the pixel FIFO.

## Interface
- NUM_CH, 1: number of ADC channels, 1..4
- ADC_BITS, 12: data bits clocked per conversion after the leading zeros
- LEAD_ZEROS, 3: leading-zero bits per conversion
- OUT_BITS, 8: FIFO data width; OUT_BITS+BIT_OFFSET <= ADC_BITS
- BIT_OFFSET, 1: LSBs discarded from the offset-corrected value
- INVERT, 1: 1 = bitwise-invert the final code before the FIFO write
- CH_BITS, 2: width of fifo_wr_ch; 2^CH_BITS >= NUM_CH
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- capture_start  in  1  one-cycle capture request
- track_counts  in  8  track phase length in clk cycles; 0 treated as 1
- val_offset  in  ADC_BITS  offset subtracted from every channel
- sdata  in  NUM_CH  serial data, bit i = channel i
- fifo_full  in  1  FIFO cannot accept a write this cycle
- capture_done  out  1  one-cycle pulse: sampling finished, sequencer may advance pixel
- overrun  out  1  one-cycle pulse: request dropped
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  OUT_BITS  converted code
- fifo_wr_ch  out  CH_BITS  channel of the current write
- sclk  out  1  shared ADC serial clock, idles high
- cs_n  out  1  shared ADC chip select, active low

## Operation
- States: IDLE, TRACK, ZEROS, READ, DRAIN. A `pending` flag (depth 1) records a request.
- capture_start in any state sets pending. If pending is already set and is not being consumed that cycle, the request is dropped and overrun pulses.
- IDLE: sclk=1, cs_n=1. If capture_start or pending, go to TRACK, clear timer, clear pending.
- TRACK: sclk=1, cs_n=1. Lasts max(track_counts,1) cycles. On its last cycle, the next state is ZEROS with registered cs_n=0 and sclk=0, and capture_done pulses for the following cycle.
- ZEROS: cs_n=0, sclk toggles every clk. Lasts 2*LEAD_ZEROS cycles; sdata is ignored.
- READ: cs_n=0, sclk toggles every clk. Lasts 2*ADC_BITS cycles.
  - On each clk edge where the registered sclk is 1, every channel shifts in sdata[i], MSB first.
  - After the last sample, cs_n=1 and sclk=1.
- Conversion, per channel:
  - diff = raw − val_offset, computed at ADC_BITS+1 bits signed.
  - If diff < 0, code = 0.
  - Else if diff >= 2^(OUT_BITS+BIT_OFFSET), code = all ones.
  - Else code = diff[OUT_BITS+BIT_OFFSET-1 : BIT_OFFSET].
  - fifo_wr_data = INVERT ? ~code : code.
- DRAIN: cs_n=1, sclk=1. Channels are written in order 0..NUM_CH-1.
  - fifo_wr_en = !fifo_full, combinational from the DRAIN state and its channel index.
  - The channel index advances only on a write.
  - After the write of channel NUM_CH-1: go to TRACK if pending or capture_start (clearing pending), else IDLE.
- Reset mid-operation: everything returns to reset values at the next edge. The pending request is lost and no FIFO write occurs.

## Timing
- Reset values: capture_done=0, overrun=0, fifo_wr_en=0, fifo_wr_data=INVERT?all ones:0 (raw=0, offset=0), fifo_wr_ch=0, sclk=1, cs_n=1, state IDLE, pending=0.
- Cycle numbering: capture_start is sampled at the edge ending cycle 0 (from IDLE); T = max(track_counts,1).
  - TRACK occupies cycles 1..T.
  - capture_done is high in cycle T+1.
  - cs_n is low over cycles T+1..T+2*LEAD_ZEROS+2*ADC_BITS.
  - First fifo_wr_en is in cycle T+2*LEAD_ZEROS+2*ADC_BITS+1 when fifo_full=0.
- Back-to-back captures: TRACK starts in the cycle after the final DRAIN write; there are no IDLE cycles.
- A request arriving in the same cycle pending is consumed re-sets pending and does not raise overrun.
- fifo_full stalls DRAIN indefinitely. The stall does not shorten the next track phase.

## Test plan
- Defaults, NUM_CH=1, track_counts=14, single request, raw 0x0A5, offset 0x020 -> capture_done in cycle 15, one write in cycle 45 with data 0xBD, ch=0.
- Saturation: raw 0x010 with offset 0x020 -> 0xFF. Raw 0x400 with offset 0 -> 0x00. With INVERT=0 the same stimulus gives 0x00 and 0xFF.
- NUM_CH=4 with distinct raw values per channel -> four consecutive writes with ch 0,1,2,3 and the correct codes; sclk toggles exactly 30 times while cs_n is low.
- capture_start pulsed during READ, then again during DRAIN -> the second capture's TRACK follows the last write with no gap, and overrun pulses once, for the DRAIN-phase request.
- fifo_full held high for 10 cycles at DRAIN entry with NUM_CH=2 -> no writes during the stall, then ch0 and ch1 written in order, with no duplicates or drops.
- Reset asserted mid-READ -> the next cycle has cs_n=1, sclk=1 and no outputs active; a later request completes normally.
